// File: rtl/local_average_frame_ctrl.sv
// Frame sequencer ahead of the local-average/pad chain: locks on SOF,
// forwards one frame, injects flush zeros, then clears the pad FIFO.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   pixel_in[8:0]       bit 8 = start-of-frame, bits 7:0 = gray value
//   pixel_in_valid      pixel_in qualifier
//   pixel_in_ready      accept indication (combinational)
//   pixel_out[8:0]      pixel to averager/pad block (registered)
//   pixel_out_valid     pixel_out qualifier
//   pad_sclr            one-cycle synchronous clear to the pad FIFO
//   col_count           column of the current pixel_out
//   line_count          line of the current pixel_out
//   frame_done          one-cycle pulse when a frame completes
//   sof_error           one-cycle pulse on a mid-frame SOF marker
module local_average_frame_ctrl #(
  parameter  int radius      = 8,
  parameter  int frame_width = 768,
  parameter  int frame_lines = 480,
  localparam int cw = (frame_width > 1) ? $clog2(frame_width) : 1,
  localparam int lw = (frame_lines > 1) ? $clog2(frame_lines) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    pixel_in,
  input  logic          pixel_in_valid,
  output logic          pixel_in_ready,
  output logic [8:0]    pixel_out,
  output logic          pixel_out_valid,
  output logic          pad_sclr,
  output logic [cw-1:0] col_count,
  output logic [lw-1:0] line_count,
  output logic          frame_done,
  output logic          sof_error
);

  localparam int total = frame_width * frame_lines;
  localparam int pw    = $clog2(total + 1);
  localparam int fw    = (radius > 1) ? $clog2(radius) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    CLEAR
  } state_t;

  state_t        state;
  logic [pw-1:0] pix_cnt;
  logic [fw-1:0] flush_cnt;
  logic          accept;
  logic          marker;

  assign marker = pixel_in_valid && pixel_in[8];
  assign accept = pixel_in_valid && pixel_in_ready;

  // A marker seen mid-frame is refused so it can restart the next frame.
  always_comb begin
    pixel_in_ready = 1'b0;
    unique case (state)
      IDLE:    pixel_in_ready = 1'b1;
      STREAM:  pixel_in_ready = !marker;
      default: pixel_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      flush_cnt       <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      pad_sclr        <= 1'b0;
      frame_done      <= 1'b0;
      sof_error       <= 1'b0;
      col_count       <= '0;
      line_count      <= '0;
    end else begin
      pixel_out_valid <= 1'b0;
      pad_sclr        <= 1'b0;
      frame_done      <= 1'b0;
      sof_error       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && pixel_in[8]) begin
            pixel_out       <= pixel_in;
            pixel_out_valid <= 1'b1;
            col_count       <= '0;
            line_count      <= '0;
            pix_cnt         <= pw'(1);
            flush_cnt       <= '0;
            state           <= (total == 1) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (marker) begin
            sof_error <= 1'b1;
            flush_cnt <= '0;
            state     <= FLUSH;
          end else if (accept) begin
            pixel_out       <= pixel_in;
            pixel_out_valid <= 1'b1;
            pix_cnt         <= pix_cnt + pw'(1);
            if (col_count == cw'(frame_width - 1)) begin
              col_count  <= '0;
              line_count <= line_count + lw'(1);
            end else begin
              col_count <= col_count + cw'(1);
            end
            if (pix_cnt == pw'(total - 1))
              state <= FLUSH;
          end
        end
        FLUSH: begin
          // Flush positions keep counting freely past the frame edge.
          pixel_out       <= '0;
          pixel_out_valid <= 1'b1;
          col_count       <= col_count + cw'(1);
          if (col_count == '1)
            line_count <= line_count + lw'(1);
          flush_cnt <= flush_cnt + fw'(1);
          if (flush_cnt == fw'(radius - 1))
            state <= CLEAR;
        end
        CLEAR: begin
          pad_sclr   <= 1'b1;
          frame_done <= 1'b1;
          col_count  <= '0;
          line_count <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_average_frame_ctrl.sv
// Bench for local_average_frame_ctrl: two configurations checked
// cycle by cycle against a frame-level reference model.
module tb_local_average_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] a_pix = '0, b_pix = '0;
  logic       a_vld = 1'b0, b_vld = 1'b0;
  logic       a_rdy, b_rdy;
  logic [8:0] a_po, b_po;
  logic       a_pv, b_pv, a_sclr, b_sclr;
  logic       a_done, b_done, a_serr, b_serr;
  logic [1:0] a_col;
  logic [0:0] a_line, b_col, b_line;

  int checks = 0;
  int errors = 0;
  bit rst = 1'b1;

  always #5 clk = ~clk;

  local_average_frame_ctrl #(
    .radius(3), .frame_width(4), .frame_lines(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .pixel_in(a_pix), .pixel_in_valid(a_vld),
    .pixel_in_ready(a_rdy),
    .pixel_out(a_po), .pixel_out_valid(a_pv),
    .pad_sclr(a_sclr),
    .col_count(a_col), .line_count(a_line),
    .frame_done(a_done), .sof_error(a_serr)
  );

  local_average_frame_ctrl #(
    .radius(1), .frame_width(1), .frame_lines(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .pixel_in(b_pix), .pixel_in_valid(b_vld),
    .pixel_in_ready(b_rdy),
    .pixel_out(b_po), .pixel_out_valid(b_pv),
    .pad_sclr(b_sclr),
    .col_count(b_col), .line_count(b_line),
    .frame_done(b_done), .sof_error(b_serr)
  );

  // Reference model: frame position plus a countdown of blocked cycles.
  int         fw[2]   = '{4, 1};
  int         fl[2]   = '{2, 1};
  int         rad[2]  = '{3, 1};
  int         cwid[2] = '{2, 1};
  bit         inf[2];
  int         pos[2];
  int         busy[2];
  bit         e_pv[2], e_sclr[2], e_done[2], e_serr[2];
  bit         e_lchk[2], e_pochk[2];
  logic [8:0] e_po[2];
  int         e_col[2], e_line[2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input bit v, input logic [8:0] d,
                       output bit rdy);
    int tot;
    tot = fw[k] * fl[k];
    e_pv[k] = 0; e_sclr[k] = 0; e_done[k] = 0; e_serr[k] = 0;
    e_pochk[k] = 0;
    if (busy[k] > 0) rdy = 0;
    else if (!inf[k]) rdy = 1;
    else rdy = !(v && d[8]);
    if (rst) begin
      inf[k] = 0; pos[k] = 0; busy[k] = 0;
      e_po[k] = '0; e_col[k] = 0; e_line[k] = 0;
      e_lchk[k] = 1; e_pochk[k] = 1;
    end else if (busy[k] > 1) begin
      e_pv[k] = 1; e_po[k] = '0; e_pochk[k] = 1;
      e_col[k] = (e_col[k] + 1) % (1 << cwid[k]);
      e_lchk[k] = 0;
      busy[k]--;
    end else if (busy[k] == 1) begin
      e_sclr[k] = 1; e_done[k] = 1;
      e_col[k] = 0; e_line[k] = 0; e_lchk[k] = 1;
      busy[k] = 0;
    end else if (!inf[k]) begin
      if (v && d[8]) begin
        e_pv[k] = 1; e_po[k] = d; e_pochk[k] = 1;
        e_col[k] = 0; e_line[k] = 0; e_lchk[k] = 1;
        pos[k] = 1;
        if (tot == 1) busy[k] = rad[k] + 1;
        else inf[k] = 1;
      end
    end else if (v && d[8]) begin
      e_serr[k] = 1; inf[k] = 0; busy[k] = rad[k] + 1;
    end else if (v) begin
      e_pv[k] = 1; e_po[k] = d; e_pochk[k] = 1;
      e_col[k] = pos[k] % fw[k]; e_line[k] = pos[k] / fw[k];
      pos[k]++;
      if (pos[k] == tot) begin
        inf[k] = 0; busy[k] = rad[k] + 1;
      end
    end
  endtask

  task automatic check_out();
    chk("a_valid", 32'(a_pv), 32'(e_pv[0]));
    chk("a_sclr", 32'(a_sclr), 32'(e_sclr[0]));
    chk("a_done", 32'(a_done), 32'(e_done[0]));
    chk("a_sof_err", 32'(a_serr), 32'(e_serr[0]));
    chk("a_col", 32'(a_col), 32'(e_col[0]));
    if (e_lchk[0]) chk("a_line", 32'(a_line), 32'(e_line[0]));
    if (e_pochk[0]) chk("a_pixel", 32'(a_po), 32'(e_po[0]));
    chk("b_valid", 32'(b_pv), 32'(e_pv[1]));
    chk("b_sclr", 32'(b_sclr), 32'(e_sclr[1]));
    chk("b_done", 32'(b_done), 32'(e_done[1]));
    chk("b_sof_err", 32'(b_serr), 32'(e_serr[1]));
    chk("b_col", 32'(b_col), 32'(e_col[1]));
    if (e_lchk[1]) chk("b_line", 32'(b_line), 32'(e_line[1]));
    if (e_pochk[1]) chk("b_pixel", 32'(b_po), 32'(e_po[1]));
  endtask

  task automatic step(input bit va, input logic [8:0] da,
                      input bit vb, input logic [8:0] db,
                      output bit acc_a, output bit acc_b);
    bit ra, rb;
    @(negedge clk);
    reset = rst;
    a_vld = va; a_pix = da;
    b_vld = vb; b_pix = db;
    #1;
    model(0, va, da, ra);
    model(1, vb, db, rb);
    if (!rst) begin
      chk("a_ready", 32'(a_rdy), 32'(ra));
      chk("b_ready", 32'(b_rdy), 32'(rb));
    end
    acc_a = va && ra && !rst;
    acc_b = vb && rb && !rst;
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle(input int n);
    bit x, y;
    repeat (n) step(0, '0, 0, '0, x, y);
  endtask

  task automatic send_a(input logic [8:0] d);
    bit acc, y;
    int n;
    n = 0;
    do begin
      step(1, d, 0, '0, acc, y);
      n++;
    end while (!acc && n < 20);
    chk("a_accept_bound", 32'(acc), 32'd1);
  endtask

  task automatic send_b(input logic [8:0] d);
    bit x, acc;
    int n;
    n = 0;
    do begin
      step(0, '0, 1, d, x, acc);
      n++;
    end while (!acc && n < 20);
    chk("b_accept_bound", 32'(acc), 32'd1);
  endtask

  initial begin
    bit x, y;
    // reset
    rst = 1;
    idle(2);
    rst = 0;
    idle(1);

    // back-to-back frame
    send_a(9'h105);
    for (int i = 1; i < 8; i++) send_a(9'(i));
    idle(6);

    // non-SOF pixels are discarded until SOF
    for (int i = 0; i < 5; i++) send_a(9'h0a0 + 9'(i));
    send_a(9'h1ff);
    for (int i = 1; i < 8; i++) send_a(9'h030 + 9'(i));
    idle(6);

    // mid-frame marker aborts, then restarts a frame
    send_a(9'h110);
    send_a(9'h011);
    send_a(9'h012);
    send_a(9'h120);
    for (int i = 1; i < 8; i++) send_a(9'h020 + 9'(i));
    idle(6);

    // marker on the final pixel slot
    send_a(9'h140);
    for (int i = 1; i < 7; i++) send_a(9'h040 + 9'(i));
    send_a(9'h150);
    for (int i = 1; i < 8; i++) send_a(9'h050 + 9'(i));
    idle(6);

    // random valid gaps
    for (int f = 0; f < 3; f++) begin
      send_a({1'b1, 8'($urandom)});
      for (int i = 1; i < 8; i++) begin
        while ($urandom % 2) idle(1);
        send_a({1'b0, 8'($urandom)});
      end
      idle(6);
    end

    // reset during the second flush cycle
    send_a(9'h1aa);
    for (int i = 1; i < 8; i++) send_a(9'h060 + 9'(i));
    idle(1);
    rst = 1;
    idle(1);
    rst = 0;
    idle(3);

    // single-pixel frames under continuous SOF input
    for (int i = 0; i < 5; i++) send_b({1'b1, 8'($urandom)});
    idle(4);

    // random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      logic [8:0] da, db;
      da = {($urandom % 10) == 0, 8'($urandom)};
      db = {($urandom % 3) == 0, 8'($urandom)};
      step(($urandom % 4) != 0, da, $urandom % 2, db, x, y);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
